// File: rtl/aes_round_sequencer_if.sv
// Bus between the AES round sequencer, its requester, the key expander and the shared round unit.
interface aes_round_sequencer_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] key_lat;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic [127:0] round_in;
  logic         final_sel;
  logic [127:0] round_out;
  logic         busy;
  logic [127:0] ciphertext;
  logic         done;
  logic         out_ack;

  modport slave (
    input  start, plaintext, key, round_key, round_out, out_ack,
    output key_lat, key_idx, round_in, final_sel, busy, ciphertext, done
  );

  modport master (
    output start, plaintext, key, round_key, round_out, out_ack,
    input  key_lat, key_idx, round_in, final_sel, busy, ciphertext, done
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES round sequencer: applies the initial key add, then steps a shared
// external round unit through NUM_ROUNDS rounds and holds the result until acknowledged.
module aes_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_round_sequencer_if.slave  bus
);

  localparam int unsigned DATA_W    = 128;
  localparam int unsigned KEY_IDX_W = 4;
  localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_W-1:0]     state_reg;
  logic [DATA_W-1:0]     key_lat;
  logic [DATA_W-1:0]     ciphertext;
  logic [KEY_IDX_W-1:0]  key_idx;
  logic                  done;
  logic                  busy;
  logic                  final_sel;
  logic                  accept;

  // A new request is taken in IDLE, or in HOLD when the result is acknowledged that same edge.
  assign accept = bus.start && ((state == IDLE) || ((state == HOLD) && bus.out_ack));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      state_reg  <= '0;
      key_lat    <= '0;
      ciphertext <= '0;
      key_idx    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      final_sel  <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if ((state == HOLD) && bus.out_ack) begin
            done  <= 1'b0;
            state <= IDLE;
          end
          if (accept) begin
            state_reg <= bus.plaintext ^ bus.key;
            key_lat   <= bus.key;
            key_idx   <= KEY_IDX_W'(1);
            busy      <= 1'b1;
            final_sel <= (LAST_IDX == KEY_IDX_W'(1));
            state     <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= bus.round_out;
          if (key_idx < LAST_IDX) begin
            key_idx   <= key_idx + KEY_IDX_W'(1);
            final_sel <= ((key_idx + KEY_IDX_W'(1)) == LAST_IDX);
          end else begin
            ciphertext <= bus.round_out;
            done       <= 1'b1;
            busy       <= 1'b0;
            final_sel  <= 1'b0;
            state      <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.round_in   = state_reg;
  assign bus.key_lat    = key_lat;
  assign bus.key_idx    = key_idx;
  assign bus.final_sel  = final_sel;
  assign bus.busy       = busy;
  assign bus.ciphertext = ciphertext;
  assign bus.done       = done;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES-128 round unit and key expander,
// known-answer vectors from a table plus directed multi-cycle corner cases.
module tb_aes_round_sequencer;

  localparam int NR = 10;

  logic clk;
  logic rst;
  aes_round_sequencer_if bus ();

  aes_round_sequencer #(.NUM_ROUNDS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] r;
    sq = b;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r + 4*c] = a[r + 4*((c + r) % 4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] key, input logic [3:0] idx);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    int          k;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    k = (int'(idx) > 10) ? 10 : int'(idx);
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  assign bus.round_key = expand_key(bus.key_lat, bus.key_idx);
  assign bus.round_out = aes_round(bus.round_in, bus.round_key, bus.final_sel);

  // ---------------- bench utilities ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key_lat"},    bus.key_lat, 128'd0);
    chk({tag, "_key_idx"},    128'(bus.key_idx), 128'd0);
    chk({tag, "_round_in"},   bus.round_in, 128'd0);
    chk({tag, "_final_sel"},  128'(bus.final_sel), 128'd0);
    chk({tag, "_busy"},       128'(bus.busy), 128'd0);
    chk({tag, "_ciphertext"}, bus.ciphertext, 128'd0);
    chk({tag, "_done"},       128'(bus.done), 128'd0);
  endtask

  // One encryption from the accepting edge to done; optionally pokes start/out_ack mid-run
  // and optionally acknowledges a previous result on the accepting edge.
  task automatic run(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp,
                     input bit inject, input bit ack_same);
    int fs_cnt;
    bus.start     = 1'b1;
    bus.plaintext = pt;
    bus.key       = k;
    bus.out_ack   = ack_same;
    tick();
    bus.start     = 1'b0;
    bus.out_ack   = 1'b0;
    bus.plaintext = ~pt;
    bus.key       = ~k;
    chk("acc_done",     128'(bus.done), 128'd0);
    chk("acc_busy",     128'(bus.busy), 128'd1);
    chk("acc_key_idx",  128'(bus.key_idx), 128'd1);
    chk("acc_key_lat",  bus.key_lat, k);
    chk("acc_round_in", bus.round_in, pt ^ k);
    fs_cnt = 0;
    for (int e = 1; e <= NR; e++) begin
      chk("step_key_idx",   128'(bus.key_idx), 128'(e));
      chk("step_final_sel", 128'(bus.final_sel), (e == NR) ? 128'd1 : 128'd0);
      if (bus.final_sel) fs_cnt++;
      if (inject && e == 4) begin
        bus.start     = 1'b1;
        bus.out_ack   = 1'b1;
        bus.plaintext = 128'hfeedface_cafebabe_0badf00d_12345678;
        bus.key       = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      end
      tick();
      bus.start   = 1'b0;
      bus.out_ack = 1'b0;
      if (e < NR) begin
        chk("step_done", 128'(bus.done), 128'd0);
        chk("step_busy", 128'(bus.busy), 128'd1);
      end
    end
    chk("end_done",       128'(bus.done), 128'd1);
    chk("end_ciphertext", bus.ciphertext, exp);
    chk("end_busy",       128'(bus.busy), 128'd0);
    chk("end_final_sel",  128'(bus.final_sel), 128'd0);
    chk("end_key_lat",    bus.key_lat, k);
    chk("end_key_idx",    128'(bus.key_idx), 128'(NR));
    chk("final_sel_cnt",  128'(fs_cnt), 128'd1);
  endtask

  task automatic ack();
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    chk("ack_done", 128'(bus.done), 128'd0);
    chk("ack_busy", 128'(bus.busy), 128'd0);
  endtask

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    vec_t         vecs [3];
    logic [127:0] ct_hold;

    vecs[0] = '{FIPS_PT, FIPS_KEY, FIPS_CT};
    vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734,
                128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    bus.out_ack   = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");

    // Reset wins over a simultaneous start.
    bus.start     = 1'b1;
    bus.plaintext = FIPS_PT;
    bus.key       = FIPS_KEY;
    tick();
    chk_all_zero("rst_prio");
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    chk("idle_busy", 128'(bus.busy), 128'd0);

    for (int v = 0; v < 3; v++) begin
      run(vecs[v].pt, vecs[v].key, vecs[v].ct, 1'b0, 1'b0);
      ack();
    end

    // out_ack in IDLE has no effect.
    bus.out_ack = 1'b1;
    tick();
    tick();
    bus.out_ack = 1'b0;
    chk("idle_ack_done",    128'(bus.done), 128'd0);
    chk("idle_ack_busy",    128'(bus.busy), 128'd0);
    chk("idle_ack_key_idx", 128'(bus.key_idx), 128'(NR));

    // start/out_ack during ROUND cycle 4 are ignored.
    run(FIPS_PT, FIPS_KEY, FIPS_CT, 1'b1, 1'b0);

    // Withheld acknowledge: result held, start without ack ignored.
    ct_hold = bus.ciphertext;
    for (int c = 0; c < 100; c++) begin
      if (c >= 10 && c < 20) begin
        bus.start     = 1'b1;
        bus.plaintext = 128'h0123456789abcdef_0123456789abcdef;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      chk("hold_done", 128'(bus.done), 128'd1);
      chk("hold_ct",   bus.ciphertext, ct_hold);
      chk("hold_busy", 128'(bus.busy), 128'd0);
    end
    bus.start = 1'b0;
    chk("hold_key_lat", bus.key_lat, FIPS_KEY);
    ack();
    tick();
    chk("post_ack_busy", 128'(bus.busy), 128'd0);
    chk("post_ack_done", 128'(bus.done), 128'd0);

    // Back-to-back: ack and new start on the same edge in HOLD.
    run(vecs[1].pt, vecs[1].key, vecs[1].ct, 1'b0, 1'b0);
    run(FIPS_PT, FIPS_KEY, FIPS_CT, 1'b0, 1'b1);
    ack();

    // Reset in the middle of a run.
    bus.start     = 1'b1;
    bus.plaintext = vecs[1].pt;
    bus.key       = vecs[1].key;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20 && bus.key_idx != 4'd6; i++) tick();
    chk("mid_reach_idx6", 128'(bus.key_idx), 128'd6);
    rst = 1'b1;
    tick();
    chk_all_zero("mid_rst");
    rst = 1'b0;
    run(FIPS_PT, FIPS_KEY, FIPS_CT, 1'b0, 1'b0);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
